// File: rtl/decode_pkg.sv
// decode_pkg
// Shared types for the pipelined RV32I main-decoder slice:
//   - opcode constants (bits [6:0] of the instruction)
//   - encodings for the immediate-source, result-source and ALU-op fields
//   - ctrl_t, the control bundle carried down the pipeline
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_PASSB = 2'b11
  } alu_op_e;

  typedef struct packed {
    imm_src_e    imm_src;
    result_src_e result_src;
    alu_op_e     alu_op;
    logic        branch;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic        j;
    logic        jump_reg;
    logic        illegal;
  } ctrl_t;

  // All-zero bundle: what a bubble or an unrecognised opcode carries.
  localparam ctrl_t CTRL_NOP = '{
    imm_src:    IMM_I,
    result_src: RES_ALU,
    alu_op:     ALU_ADD,
    branch:     1'b0,
    mem_write:  1'b0,
    alu_src:    1'b0,
    reg_write:  1'b0,
    j:          1'b0,
    jump_reg:   1'b0,
    illegal:    1'b0
  };

endpackage

// File: rtl/opcode_decode.sv
// opcode_decode
// Purely combinational main decoder: 7-bit opcode -> ctrl_t.
// Unknown opcodes decode to an all-zero NOP with the illegal flag set.
// Ports:
//   op   in  [6:0]  instruction opcode
//   ctrl out ctrl_t decoded control bundle
module opcode_decode
  import decode_pkg::*;
(
  input  logic [6:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    unique case (op)
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.imm_src    = IMM_I;
        ctrl.alu_op     = ALU_ADD;
      end
      OPC_OPIMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_op    = ALU_FUNCT;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
        ctrl.alu_op    = ALU_ADD;
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      OPC_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_src = IMM_B;
        ctrl.alu_op  = ALU_SUB;
      end
      OPC_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.j          = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
      end
      OPC_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.j          = 1'b1;
        ctrl.jump_reg   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.result_src = RES_PC4;
        ctrl.alu_op     = ALU_ADD;
      end
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_op    = ALU_PASSB;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
// Pipelined RV32I main decoder between IF/ID and ID/EX. The opcode is decoded
// once and the control bundle travels through PIPE_DEPTH register stages under
// a valid/ready handshake; bubbles are kept, never compressed.
// Optional feature macro: ILLEGAL_TRAP_EN (adds trap / trap_ack).
// Parameters:
//   PIPE_DEPTH  number of control stages (1..4), latency in cycles
//   CNT_W       width of the saturating illegal-opcode counter
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   input handshake, op is the 7-bit opcode
//   flush               invalidates every in-flight entry on the next edge
//   out_valid/out_ready output handshake
//   ImmSrc..JumpReg     decoded control fields
//   illegal             output entry held an unrecognised opcode
//   illegal_cnt         accepted illegal opcodes, saturating
//   trap, trap_ack      (ILLEGAL_TRAP_EN only) sticky trap on a consumed
//                       illegal entry, cleared by trap_ack or flush
module decode_ctrl_pipe
  import decode_pkg::*;
#(
  parameter int PIPE_DEPTH = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUOp,
  output logic             Branch,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic             J,
  output logic             JumpReg,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             trap,
  input  logic             trap_ack
`endif
);

  ctrl_t dec_ctrl;
  ctrl_t out_ctrl;
  logic  en;
  logic  accept;
  logic  trap_hold;
  logic  last_vld;
  ctrl_t last_ctrl;

  opcode_decode u_decode (
    .op   (op),
    .ctrl (dec_ctrl)
  );

`ifdef ILLEGAL_TRAP_EN
  assign trap_hold = trap;
`else
  assign trap_hold = 1'b0;
`endif

  // A pending trap freezes the pipeline and hides its output, so nothing
  // behind the offending instruction is lost while the trap is serviced.
  assign out_valid = last_vld & ~trap_hold;
  assign en        = ~trap_hold & (out_ready | ~out_valid);
  assign in_ready  = en;
  assign accept    = in_valid & in_ready;

  // Each stage owns its own valid bit and bundle; invalid stages always hold
  // an all-zero bundle so the outputs are zero whenever out_valid is low.
  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : gen_stage
    logic  vld;
    ctrl_t ctrl;

    if (g == 0) begin : g_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld  <= 1'b0;
          ctrl <= CTRL_NOP;
        end else if (flush) begin
          vld  <= 1'b0;
          ctrl <= CTRL_NOP;
        end else if (en) begin
          vld  <= in_valid;
          ctrl <= in_valid ? dec_ctrl : CTRL_NOP;
        end
      end
    end else begin : g_next
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld  <= 1'b0;
          ctrl <= CTRL_NOP;
        end else if (flush) begin
          vld  <= 1'b0;
          ctrl <= CTRL_NOP;
        end else if (en) begin
          vld  <= gen_stage[g-1].vld;
          ctrl <= gen_stage[g-1].ctrl;
        end
      end
    end
  end

  assign last_vld  = gen_stage[PIPE_DEPTH-1].vld;
  assign last_ctrl = gen_stage[PIPE_DEPTH-1].ctrl;
  assign out_ctrl  = out_valid ? last_ctrl : CTRL_NOP;

  assign ImmSrc    = out_ctrl.imm_src;
  assign ResultSrc = out_ctrl.result_src;
  assign ALUOp     = out_ctrl.alu_op;
  assign Branch    = out_ctrl.branch;
  assign MemWrite  = out_ctrl.mem_write;
  assign ALUSrc    = out_ctrl.alu_src;
  assign RegWrite  = out_ctrl.reg_write;
  assign J         = out_ctrl.j;
  assign JumpReg   = out_ctrl.jump_reg;
  assign illegal   = out_ctrl.illegal;

  // Counts illegal opcodes at acceptance; an input dropped by a simultaneous
  // flush was never accepted into the pipe and is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (accept && !flush && dec_ctrl.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap <= 1'b0;
    end else if (flush || trap_ack) begin
      trap <= 1'b0;
    end else if (out_valid && out_ready && last_ctrl.illegal) begin
      trap <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe
// Randomised and directed stimulus for decode_ctrl_pipe (PIPE_DEPTH=2,
// CNT_W=2), compared each cycle against a transaction-level reference: a
// queue of accepted instructions, each tagged with how many advancing cycles
// it has spent inside the block.
module tb_decode_ctrl_pipe;

  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    op = 7'd0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2:0]    ImmSrc;
  logic [1:0]    ResultSrc;
  logic [1:0]    ALUOp;
  logic          Branch, MemWrite, ALUSrc, RegWrite, J, JumpReg, illegal;
  logic [CW-1:0] illegal_cnt;
`ifdef ILLEGAL_TRAP_EN
  logic          trap;
  logic          trap_ack = 1'b1;
`endif

  decode_ctrl_pipe #(.PIPE_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ImmSrc      (ImmSrc),
    .ResultSrc   (ResultSrc),
    .ALUOp       (ALUOp),
    .Branch      (Branch),
    .MemWrite    (MemWrite),
    .ALUSrc      (ALUSrc),
    .RegWrite    (RegWrite),
    .J           (J),
    .JumpReg     (JumpReg),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
`ifdef ILLEGAL_TRAP_EN
    ,
    .trap        (trap),
    .trap_ack    (trap_ack)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] c;
    int          age;
  } ent_t;

  ent_t       q[$];
  int         mcnt = 0;
  int         checks = 0;
  int         errors = 0;
  logic [6:0] legal_ops [8];

  // Expected bundle straight from the decode table, packed as
  // {ImmSrc, ResultSrc, ALUOp, Branch, MemWrite, ALUSrc, RegWrite, J, JumpReg, illegal}.
  function automatic logic [13:0] expCtrl(input logic [6:0] o);
    case (o)
      7'b0000011: return {3'b000, 2'b01, 2'b00, 7'b0011000};
      7'b0010011: return {3'b000, 2'b00, 2'b10, 7'b0011000};
      7'b0100011: return {3'b001, 2'b00, 2'b00, 7'b0110000};
      7'b0110011: return {3'b000, 2'b00, 2'b10, 7'b0001000};
      7'b1100011: return {3'b010, 2'b00, 2'b01, 7'b1000000};
      7'b1101111: return {3'b011, 2'b10, 2'b00, 7'b0001100};
      7'b1100111: return {3'b000, 2'b10, 2'b00, 7'b0011110};
      7'b0110111: return {3'b100, 2'b00, 2'b11, 7'b0011000};
      default:    return {3'b000, 2'b00, 2'b00, 7'b0000001};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [13:0] dutCtrl();
    return {ImmSrc, ResultSrc, ALUOp, Branch, MemWrite, ALUSrc, RegWrite, J, JumpReg, illegal};
  endfunction

  // One clock cycle: drive inputs, compare against the reference, then let
  // the reference advance exactly as the coming edge should.
  task automatic applyStimulus(input logic v, input logic [6:0] o, input logic f, input logic r);
    logic        mvalid;
    logic [13:0] mctrl;
    logic        men;
    @(negedge clk);
    in_valid  = v;
    op        = o;
    flush     = f;
    out_ready = r;
    #1;
    mvalid = (q.size() > 0) && (q[0].age == DEPTH);
    mctrl  = mvalid ? q[0].c : 14'd0;
    men    = r | ~mvalid;
    checkOutput("out_valid",   {31'd0, out_valid}, {31'd0, mvalid});
    checkOutput("ctrl",        {18'd0, dutCtrl()}, {18'd0, mctrl});
    checkOutput("in_ready",    {31'd0, in_ready},  {31'd0, men});
    checkOutput("illegal_cnt", {30'd0, illegal_cnt}, mcnt);
    if (v && men && !f && expCtrl(o)[0] && mcnt < (1 << CW) - 1) mcnt++;
    if (f) begin
      q.delete();
    end else if (men) begin
      if (mvalid) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (v) q.push_back('{c: expCtrl(o), age: 1});
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_ctrl",      {18'd0, dutCtrl()}, 32'd0);
    checkOutput("rst_cnt",       {30'd0, illegal_cnt}, 32'd0);
    q.delete();
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    legal_ops = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011,
                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    doReset();

    // Single LOAD, observed DEPTH cycles later.
    applyStimulus(1'b1, 7'b0000011, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 7'd0, 1'b0, 1'b1);

    // All legal opcodes back to back followed by an illegal one.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, legal_ops[i], 1'b0, 1'b1);
    applyStimulus(1'b1, 7'b1111111, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 7'd0, 1'b0, 1'b1);
    checkOutput("cnt_after_stream", {30'd0, illegal_cnt}, 32'd1);

    // Fill, stall three cycles, then drain.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, legal_ops[i], 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, legal_ops[3], 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 7'd0, 1'b0, 1'b1);

    // Flush collides with a LUI; nothing should emerge.
    applyStimulus(1'b1, legal_ops[0], 1'b0, 1'b1);
    applyStimulus(1'b1, 7'b0110111, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 7'd0, 1'b0, 1'b1);
    checkOutput("cnt_after_flush", {30'd0, illegal_cnt}, 32'd1);

    // Saturation of the 2-bit counter.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 7'b0000000, 1'b0, 1'b1);
      checkOutput("cnt_sat_model", mcnt, (i < 3) ? i + 1 : 3);
    end
    repeat (3) applyStimulus(1'b0, 7'd0, 1'b0, 1'b1);

    // Random traffic with stalls, flushes and the odd reset.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      logic       v, f, r;
      logic [6:0] o;
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 19) == 0);
      o = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 7)] : 7'($urandom);
      applyStimulus(v, o, f, r);
      if (n % 700 == 699) doReset();
    end
    repeat (4) applyStimulus(1'b0, 7'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
